// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  localparam int          WORD_W  = 16;

endpackage

// File: rtl/lc3_mem_responder_array.sv
// DEPTH x 16 word store: synchronous write, asynchronous read, contents survive reset.
module lc3_mem_array
  import lc3_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 MAR/MDR memory responder: one request at a time, WAIT_STATES wait cycles, one-cycle Mem_R.
// Optional build macro MEM_IO_MAP_EN maps address 16'hFFFF to Switches (read) / Hex_Out (write).
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Mem_CE,
  input  logic              Mem_WE,
  input  logic [15:0]       Mem_ADDR,
  input  logic [WORD_W-1:0] Mem_WDATA,
  output logic [WORD_W-1:0] Mem_RDATA,
  output logic              Mem_R,
  output logic              Mem_Busy
`ifdef MEM_IO_MAP_EN
  ,
  input  logic [WORD_W-1:0] Switches,
  output logic [WORD_W-1:0] Hex_Out
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  mem_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               enter_done;

  logic [15:0]        addr_q;
  logic               we_q;
  logic [WORD_W-1:0]  wdata_q;

  logic [15:0]        req_addr;
  logic               req_we;
  logic [WORD_W-1:0]  req_wdata;
  logic               is_io;
  logic               ram_we;
  logic [WORD_W-1:0]  ram_rdata;
  logic [WORD_W-1:0]  rdata_q, rdata_d;
  logic               unused_addr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (Mem_CE) begin
          if (WAIT_STATES == 0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!Mem_CE) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture: data path only, no reset needed.
  always_ff @(posedge Clk) begin
    if (state_q == IDLE && Mem_CE) begin
      addr_q  <= Mem_ADDR;
      we_q    <= Mem_WE;
      wdata_q <= Mem_WDATA;
    end
  end

  // With zero wait states DONE is entered on the capture edge, so the live inputs stand in for the latch.
  assign req_addr  = (state_q == IDLE) ? Mem_ADDR  : addr_q;
  assign req_we    = (state_q == IDLE) ? Mem_WE    : we_q;
  assign req_wdata = (state_q == IDLE) ? Mem_WDATA : wdata_q;
  assign unused_addr = ^req_addr;

`ifdef MEM_IO_MAP_EN
  assign is_io = (req_addr == IO_ADDR);
`else
  assign is_io = 1'b0;
`endif

  // Gating with Reset_n keeps a write from landing while reset holds the FSM in IDLE.
  assign ram_we = enter_done & req_we & ~is_io & Reset_n;

  lc3_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .addr_i  (req_addr[AW-1:0]),
    .wdata_i (req_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rdata_d = ram_rdata;
`ifdef MEM_IO_MAP_EN
    if (is_io) begin
      rdata_d = Switches;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdata_q <= '0;
    end else if (enter_done && !req_we) begin
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_IO_MAP_EN
  logic [WORD_W-1:0] hex_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hex_q <= '0;
    end else if (enter_done && req_we && is_io) begin
      hex_q <= req_wdata;
    end
  end

  assign Hex_Out = hex_q;
`endif

  assign Mem_RDATA = rdata_q;
  assign Mem_R     = (state_q == DONE);
  assign Mem_Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder (WAIT_STATES=2 main instance, WAIT_STATES=0 second instance).
module tb_lc3_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 2;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        CE, WE;
  logic [15:0] ADDR, WDATA, RDATA;
  logic        R, Busy;
  logic        CE0, WE0;
  logic [15:0] ADDR0, WDATA0, RDATA0;
  logic        R0, Busy0;
`ifdef MEM_IO_MAP_EN
  logic [15:0] sw, hex, sw0, hex0;
`endif

  int checks = 0;
  int passes = 0;

  logic [15:0] mmem   [DEPTH];
  bit          mknown [DEPTH];
  logic [15:0] m_rdata;
  bit          m_rd_known;
`ifdef MEM_IO_MAP_EN
  logic [15:0] m_hex;
`endif

  always #5 Clk = ~Clk;

  lc3_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_CE(CE), .Mem_WE(WE), .Mem_ADDR(ADDR),
    .Mem_WDATA(WDATA), .Mem_RDATA(RDATA), .Mem_R(R), .Mem_Busy(Busy)
`ifdef MEM_IO_MAP_EN
    , .Switches(sw), .Hex_Out(hex)
`endif
  );

  lc3_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_CE(CE0), .Mem_WE(WE0), .Mem_ADDR(ADDR0),
    .Mem_WDATA(WDATA0), .Mem_RDATA(RDATA0), .Mem_R(R0), .Mem_Busy(Busy0)
`ifdef MEM_IO_MAP_EN
    , .Switches(sw0), .Hex_Out(hex0)
`endif
  );

  // One full request on the main instance, checked against the model.
  task automatic do_req(input bit we, input logic [15:0] addr, input logic [15:0] data,
                        input bit scramble, input string tag);
    int  n;
    bit  seen;
    bit  busy_ok;
    int  idx;
    bit  io;
    logic [15:0] exp;
    @(negedge Clk);
    CE = 1'b1; WE = we; ADDR = addr; WDATA = data;
    n = 0; seen = 0; busy_ok = 1;
    while (n < 20) begin
      @(negedge Clk);
      n++;
      if (R === 1'b1) begin
        seen = 1;
        break;
      end
      if (Busy !== 1'b1) busy_ok = 0;
      if (scramble && n == 1) begin
        ADDR = 16'($urandom); WDATA = 16'($urandom); WE = ~we;
      end
    end
    checks++;
    if (!seen || n != WS + 1) $display("FAIL %s latency: got %0d cycles (seen=%0d), want %0d", tag, n, seen, WS + 1);
    else passes++;
    checks++;
    if (!busy_ok) $display("FAIL %s busy_in_wait: got 0, want 1", tag);
    else passes++;

    idx = int'(addr) % DEPTH;
    io = 0;
`ifdef MEM_IO_MAP_EN
    io = (addr == 16'hFFFF);
`endif
    if (we) begin
      if (io) begin
`ifdef MEM_IO_MAP_EN
        m_hex = data;
`endif
      end else begin
        mmem[idx] = data; mknown[idx] = 1;
      end
    end else begin
      if (io) begin
`ifdef MEM_IO_MAP_EN
        m_rdata = sw; m_rd_known = 1;
`endif
      end else begin
        m_rdata = mmem[idx]; m_rd_known = mknown[idx];
      end
    end
    if (m_rd_known) begin
      exp = m_rdata;
      checks++;
      if (RDATA !== exp) $display("FAIL %s rdata: got %h, want %h", tag, RDATA, exp);
      else passes++;
    end
    CE = 1'b0;
    @(negedge Clk);
    checks++;
    if (R !== 1'b0 || Busy !== 1'b0) $display("FAIL %s pulse_end: R=%b Busy=%b, want 0 0", tag, R, Busy);
    else passes++;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    CE = 0; WE = 0; ADDR = 0; WDATA = 0;
    CE0 = 0; WE0 = 0; ADDR0 = 0; WDATA0 = 0;
    repeat (2) @(negedge Clk);
    checks++;
    if (R !== 1'b0 || Busy !== 1'b0) $display("FAIL reset_ctrl: R=%b Busy=%b, want 0 0", R, Busy);
    else passes++;
    checks++;
    if (RDATA !== 16'h0000) $display("FAIL reset_rdata: got %h, want 0000", RDATA);
    else passes++;
    checks++;
    if (R0 !== 1'b0 || Busy0 !== 1'b0 || RDATA0 !== 16'h0000)
      $display("FAIL reset_dut0: R=%b Busy=%b RDATA=%h, want 0 0 0000", R0, Busy0, RDATA0);
    else passes++;
`ifdef MEM_IO_MAP_EN
    checks++;
    if (hex !== 16'h0000) $display("FAIL reset_hex: got %h, want 0000", hex);
    else passes++;
`endif
    Reset_n = 1'b1;
    m_rdata = 16'h0000; m_rd_known = 1;
  endtask

  task automatic test_write_read();
    do_req(1, 16'h0010, 16'h1234, 0, "wr_0010");
    do_req(0, 16'h0010, 16'h0000, 0, "rd_0010");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a;
      a = {6'($urandom), 7'd0, 3'($urandom)};
      do_req(1'($urandom), a, 16'($urandom), 1'($urandom), "rand");
    end
  endtask

  task automatic test_wrap();
    do_req(1, 16'h0403, 16'hA5A5, 0, "wrap_wr");
    do_req(0, 16'h0003, 16'h0000, 0, "wrap_rd");
  endtask

  task automatic test_abort();
    bit r_seen;
    do_req(1, 16'h0020, 16'h5555, 0, "abort_pre");
    @(negedge Clk);
    CE = 1; WE = 1; ADDR = 16'h0020; WDATA = 16'hFFFF;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b1) $display("FAIL abort_in_wait: Busy=%b, want 1", Busy);
    else passes++;
    CE = 0;
    r_seen = 0;
    repeat (4) begin
      @(negedge Clk);
      if (R !== 1'b0) r_seen = 1;
    end
    checks++;
    if (r_seen || Busy !== 1'b0) $display("FAIL abort_idle: r_seen=%0d Busy=%b, want 0 0", r_seen, Busy);
    else passes++;
    do_req(0, 16'h0020, 16'h0000, 0, "abort_rd");
  endtask

  task automatic test_reset_midwrite();
    bit r_seen;
    do_req(1, 16'h0005, 16'h1111, 0, "rst_pre_wr");
    do_req(0, 16'h0005, 16'h0000, 0, "rst_pre_rd");
    @(negedge Clk);
    CE = 1; WE = 1; ADDR = 16'h0005; WDATA = 16'hBEEF;
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    CE = 0;
    #1;
    checks++;
    if (R !== 1'b0 || Busy !== 1'b0 || RDATA !== 16'h0000)
      $display("FAIL rst_async: R=%b Busy=%b RDATA=%h, want 0 0 0000", R, Busy, RDATA);
    else passes++;
    r_seen = 0;
    repeat (3) begin
      @(negedge Clk);
      if (R !== 1'b0) r_seen = 1;
    end
    Reset_n = 1'b1;
    m_rdata = 16'h0000; m_rd_known = 1;
`ifdef MEM_IO_MAP_EN
    m_hex = 16'h0000;
`endif
    repeat (3) begin
      @(negedge Clk);
      if (R !== 1'b0) r_seen = 1;
    end
    checks++;
    if (r_seen) $display("FAIL rst_no_pulse: Mem_R seen 1, want never");
    else passes++;
    do_req(0, 16'h0005, 16'h0000, 0, "rst_post_rd");
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    bit          exp_r;
    v = 16'($urandom) | 16'h0001;
    @(negedge Clk);
    CE0 = 1; WE0 = 1; ADDR0 = 16'h0007; WDATA0 = v;
    @(negedge Clk);
    checks++;
    if (R0 !== 1'b1) $display("FAIL b2b_wr_pulse: R=%b, want 1", R0);
    else passes++;
    CE0 = 0;
    @(negedge Clk);
    checks++;
    if (R0 !== 1'b0 || Busy0 !== 1'b0 || RDATA0 !== 16'h0000)
      $display("FAIL b2b_wr_after: R=%b Busy=%b RDATA=%h, want 0 0 0000", R0, Busy0, RDATA0);
    else passes++;
    CE0 = 1; WE0 = 0; ADDR0 = 16'h0007;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      exp_r = (i % 2 == 0);
      checks++;
      if (R0 !== exp_r || Busy0 !== exp_r)
        $display("FAIL b2b_cycle%0d: R=%b Busy=%b, want %b %b", i, R0, Busy0, exp_r, exp_r);
      else passes++;
      if (exp_r) begin
        checks++;
        if (RDATA0 !== v) $display("FAIL b2b_rdata%0d: got %h, want %h", i, RDATA0, v);
        else passes++;
      end
    end
    CE0 = 0;
    @(negedge Clk);
  endtask

`ifdef MEM_IO_MAP_EN
  task automatic test_io();
    sw = 16'h00C3;
    do_req(1, 16'h03FF, 16'h6A6A, 0, "io_pre");
    do_req(0, 16'hFFFF, 16'h0000, 0, "io_rd");
    do_req(1, 16'hFFFF, 16'h0042, 0, "io_wr");
    checks++;
    if (hex !== m_hex) $display("FAIL io_hex: got %h, want %h", hex, m_hex);
    else passes++;
    do_req(0, 16'h03FF, 16'h0000, 0, "io_ram_untouched");
  endtask
`endif

  initial begin
`ifdef MEM_IO_MAP_EN
    sw = 16'h0000; sw0 = 16'h0000; m_hex = 16'h0000;
`endif
    for (int i = 0; i < DEPTH; i++) mknown[i] = 0;
    test_reset();
    test_write_read();
    test_wrap();
    test_abort();
    test_random();
    test_reset_midwrite();
    test_back_to_back();
`ifdef MEM_IO_MAP_EN
    test_io();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
